// File: rtl/clk_rst_seq_pkg.sv
// Shared types and helpers for the clock-enable / reset sequencer.
// Optional stats counters are enabled with CLK_RST_SEQ_STATS_EN.
package clk_rst_seq_pkg;

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } ch_state_e;

    localparam int unsigned CNT_W_DEF = 8;

    function automatic int unsigned hold_init(
        input int unsigned idx,
        input int unsigned rst_cycles,
        input int unsigned stagger
    );
        return rst_cycles + idx * stagger;
    endfunction

endpackage

// File: rtl/clk_rst_seq_ch.sv
// One sequencer channel: HOLD/RUN reset FSM, clock-enable divider and
// (with CLK_RST_SEQ_STATS_EN) a saturating soft-reset counter.
module clk_rst_seq_ch
    import clk_rst_seq_pkg::*;
#(
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned HOLD_INIT = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [CNT_W-1:0] div_i,
    input  logic             rst_req_i,
    input  logic [CNT_W-1:0] rst_len_i,
    output logic             clk_en_o,
    output logic             rst_n_o,
    output logic             busy_o
`ifdef CLK_RST_SEQ_STATS_EN
    ,
    output logic [7:0]       rst_cnt_o
`endif
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_INIT);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             en_q, en_d;

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        if (rst_req_i) begin
            state_d = HOLD;
            hcnt_d  = (rst_len_i == '0) ? ONE : rst_len_i;
        end else if (state_q == HOLD) begin
            if (hcnt_q <= ONE) state_d = RUN;
            else               hcnt_d  = hcnt_q - ONE;
        end
    end

    // Divide value is only picked up at wrap, so a period always completes.
    always_comb begin
        en_d   = (dcnt_q == div_q);
        dcnt_d = en_d ? '0 : dcnt_q + ONE;
        div_d  = en_d ? div_i : div_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= HOLD;
            hcnt_q  <= HOLD_LD;
            dcnt_q  <= '0;
            div_q   <= div_i;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            dcnt_q  <= dcnt_d;
            div_q   <= div_d;
            en_q    <= en_d;
        end
    end

    assign clk_en_o = en_q;
    assign rst_n_o  = (state_q == RUN);
    assign busy_o   = (state_q != RUN);

`ifdef CLK_RST_SEQ_STATS_EN
    logic [7:0] scnt_q, scnt_d;

    always_comb begin
        scnt_d = scnt_q;
        if (rst_req_i && scnt_q != 8'hFF) scnt_d = scnt_q + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) scnt_q <= '0;
        else         scnt_q <= scnt_d;
    end

    assign rst_cnt_o = scnt_q;
`endif

endmodule

// File: rtl/clk_rst_seq.sv
// Multi-channel clock-enable and staggered reset sequencer (top).
// Define CLK_RST_SEQ_STATS_EN to add the ch_rst_cnt output.
module clk_rst_seq
    import clk_rst_seq_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned RST_CYCLES = 10,
    parameter int unsigned STAGGER    = 4
) (
    input  logic                    clk_fr,
    input  logic                    rst,
    input  logic [NUM_CH*CNT_W-1:0] ch_div,
    input  logic [NUM_CH-1:0]       ch_rst_req,
    input  logic [CNT_W-1:0]        ch_rst_len,
    output logic [NUM_CH-1:0]       ch_clk_en,
    output logic [NUM_CH-1:0]       ch_rst_n,
    output logic [NUM_CH-1:0]       ch_busy,
    output logic                    all_rdy
`ifdef CLK_RST_SEQ_STATS_EN
    ,
    output logic [NUM_CH*8-1:0]     ch_rst_cnt
`endif
);

    localparam longint MAX_HOLD =
        longint'(RST_CYCLES) + longint'(NUM_CH - 1) * longint'(STAGGER);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_nch
        $fatal(1, "clk_rst_seq: NUM_CH must be 1..16");
    end
    if (MAX_HOLD >= (longint'(1) << CNT_W)) begin : g_bad_hold
        $fatal(1, "clk_rst_seq: hold length does not fit CNT_W");
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_rst_seq_ch #(
            .CNT_W    (CNT_W),
            .HOLD_INIT(hold_init(k, RST_CYCLES, STAGGER))
        ) u_ch (
            .clk_i    (clk_fr),
            .rst_ni   (rst),
            .div_i    (ch_div[k*CNT_W +: CNT_W]),
            .rst_req_i(ch_rst_req[k]),
            .rst_len_i(ch_rst_len),
            .clk_en_o (ch_clk_en[k]),
            .rst_n_o  (ch_rst_n[k]),
            .busy_o   (ch_busy[k])
`ifdef CLK_RST_SEQ_STATS_EN
            ,
            .rst_cnt_o(ch_rst_cnt[k*8 +: 8])
`endif
        );
    end

    // A request in flight already counts as not-ready, one cycle ahead of state.
    logic all_rdy_q, all_rdy_d;

    always_comb begin
        all_rdy_d = (&(~ch_busy)) & ~(|ch_rst_req);
    end

    always_ff @(posedge clk_fr) begin
        if (!rst) all_rdy_q <= 1'b0;
        else      all_rdy_q <= all_rdy_d;
    end

    assign all_rdy = all_rdy_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed-vector bench for clk_rst_seq with default parameters.
module tb_clk_rst_seq;

    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int LOGN = 1024;

    logic              clk_fr = 1'b0;
    logic              rst;
    logic [NCH*CW-1:0] ch_div;
    logic [NCH-1:0]    ch_rst_req;
    logic [CW-1:0]     ch_rst_len;
    logic [NCH-1:0]    ch_clk_en;
    logic [NCH-1:0]    ch_rst_n;
    logic [NCH-1:0]    ch_busy;
    logic              all_rdy;
`ifdef CLK_RST_SEQ_STATS_EN
    logic [NCH*8-1:0]  ch_rst_cnt;
`endif

    clk_rst_seq dut (
        .clk_fr    (clk_fr),
        .rst       (rst),
        .ch_div    (ch_div),
        .ch_rst_req(ch_rst_req),
        .ch_rst_len(ch_rst_len),
        .ch_clk_en (ch_clk_en),
        .ch_rst_n  (ch_rst_n),
        .ch_busy   (ch_busy),
        .all_rdy   (all_rdy)
`ifdef CLK_RST_SEQ_STATS_EN
        ,
        .ch_rst_cnt(ch_rst_cnt)
`endif
    );

    always #5 clk_fr = ~clk_fr;

    int cyc = -100;
    logic [NCH-1:0] en_log   [LOGN];
    logic [NCH-1:0] rstn_log [LOGN];
    logic           rdy_log  [LOGN];

    always @(negedge clk_fr) begin
        if (cyc >= 0 && cyc < LOGN) begin
            en_log[cyc]   = ch_clk_en;
            rstn_log[cyc] = ch_rst_n;
            rdy_log[cyc]  = all_rdy;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_fr);
        #1;
        cyc++;
    endtask

    function automatic int first_on(input int k, input int base, input int lim);
        for (int c = base; c < base + lim; c++)
            if (rstn_log[c][k] === 1'b1) return c - base;
        return -1;
    endfunction

    function automatic int first_rdy(input int base, input int lim);
        for (int c = base; c < base + lim; c++)
            if (rdy_log[c] === 1'b1) return c - base;
        return -1;
    endfunction

    function automatic int first_en(input int k, input int base, input int lim);
        for (int c = base; c < base + lim; c++)
            if (en_log[c][k] === 1'b1) return c - base;
        return -1;
    endfunction

    function automatic int n_low(input int k, input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++)
            if (rstn_log[c][k] !== 1'b1) n++;
        return n;
    endfunction

    function automatic int n_rdy_low(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++)
            if (rdy_log[c] !== 1'b1) n++;
        return n;
    endfunction

    function automatic int n_en(input int k, input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++)
            if (en_log[c][k] === 1'b1) n++;
        return n;
    endfunction

    int exp_first [NCH] = '{1, 2, 4, 8};
    int exp_npls  [NCH] = '{39, 19, 9, 4};

    initial begin
        int p, q, r, m4, base;
`ifdef CLK_RST_SEQ_STATS_EN
        int s0;
`endif
        rst        = 1'b0;
        ch_div     = {8'd7, 8'd3, 8'd1, 8'd0};
        ch_rst_req = '0;
        ch_rst_len = '0;
        repeat (3) tick();

        chk("rst_clk_en", 32'(ch_clk_en), 32'd0);
        chk("rst_rst_n",  32'(ch_rst_n),  32'd0);
        chk("rst_busy",   32'(ch_busy),   32'hF);
        chk("rst_all_rdy", 32'(all_rdy),  32'd0);

        // power-up stagger and dividers
        rst = 1'b1;
        cyc = 0;
        repeat (40) tick();
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("rise%0d", k), first_on(k, 0, 40), 10 + 4 * k);
            chk($sformatf("en_first%0d", k), first_en(k, 0, 40), exp_first[k]);
            chk($sformatf("en_count%0d", k), n_en(k, 0, 39), exp_npls[k]);
        end
        chk("all_rdy_rise", first_rdy(0, 40), 23);
        chk("en3_in_hold", 32'(en_log[16][3] & ~rstn_log[16][3]), 32'd1);

        // soft reset ch2, len 5
        p = cyc;
        ch_rst_len = 8'd5;
        ch_rst_req = 4'b0100;
        tick();
        ch_rst_req = '0;
        repeat (14) tick();
        chk("sr2_low", n_low(2, p, p + 14), 5);
        chk("sr2_first", 32'(rstn_log[p + 1][2]), 32'd0);
        chk("sr2_back", 32'(rstn_log[p + 6][2]), 32'd1);
        chk("sr2_rdy_low", n_rdy_low(p, p + 14), 6);
        chk("sr2_others",
            n_low(0, p, p + 14) + n_low(1, p, p + 14) + n_low(3, p, p + 14), 0);

        // re-request ch1 in its 3rd HOLD cycle
`ifdef CLK_RST_SEQ_STATS_EN
        s0 = int'(ch_rst_cnt[15:8]);
`endif
        q = cyc;
        ch_rst_len = 8'd5;
        ch_rst_req = 4'b0010;
        tick();
        ch_rst_req = '0;
        tick();
        tick();
        ch_rst_len = 8'd8;
        ch_rst_req = 4'b0010;
        tick();
        ch_rst_req = '0;
        repeat (16) tick();
        chk("rr1_low", n_low(1, q, q + 19), 11);
        chk("rr1_last", 32'(rstn_log[q + 11][1]), 32'd0);
        chk("rr1_back", 32'(rstn_log[q + 12][1]), 32'd1);
`ifdef CLK_RST_SEQ_STATS_EN
        chk("rr1_stats", int'(ch_rst_cnt[15:8]) - s0, 2);
`endif

        // zero length behaves as one cycle
        r = cyc;
        ch_rst_len = 8'd0;
        ch_rst_req = 4'b0001;
        tick();
        ch_rst_req = '0;
        repeat (5) tick();
        chk("len0_low", n_low(0, r, r + 5), 1);

        // ch2 divide 3 -> 1 just after a pulse
        for (int i = 0; i < 4 && (cyc % 4) != 1; i++) tick();
        m4 = cyc - 1;
        ch_div[2*CW +: CW] = 8'd1;
        repeat (10) tick();
        chk("div_pulse0", 32'(en_log[m4][2]),     32'd1);
        chk("div_old2",   32'(en_log[m4 + 2][2]), 32'd0);
        chk("div_old3",   32'(en_log[m4 + 3][2]), 32'd0);
        chk("div_old4",   32'(en_log[m4 + 4][2]), 32'd1);
        chk("div_new5",   32'(en_log[m4 + 5][2]), 32'd0);
        chk("div_new6",   32'(en_log[m4 + 6][2]), 32'd1);
        chk("div_count",  n_en(2, m4 + 1, m4 + 8), 3);

        // global reset with ch0 mid-HOLD and others in RUN
        ch_div = {8'd7, 8'd3, 8'd1, 8'd0};
        ch_rst_len = 8'd20;
        ch_rst_req = 4'b0001;
        tick();
        ch_rst_req = '0;
        repeat (3) tick();
        rst = 1'b0;
        ch_rst_req = 4'b1000;
        tick();
        chk("rst2_clk_en", 32'(ch_clk_en), 32'd0);
        chk("rst2_rst_n",  32'(ch_rst_n),  32'd0);
        chk("rst2_busy",   32'(ch_busy),   32'hF);
        chk("rst2_rdy",    32'(all_rdy),   32'd0);
`ifdef CLK_RST_SEQ_STATS_EN
        chk("rst2_stats", 32'(ch_rst_cnt), 32'd0);
`endif
        rst = 1'b1;
        ch_rst_req = '0;
        base = cyc;
        repeat (30) tick();
        for (int k = 0; k < NCH; k++)
            chk($sformatf("rise2_%0d", k), first_on(k, base, 30), 10 + 4 * k);
        chk("all_rdy_rise2", first_rdy(base, 30), 23);
        chk("en_first2_3", first_en(3, base, 30), 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
